spi_master_multi: RTL and testbench
===================================

// Module: spi_master_multi
// PURPOSE
//  Parametrised SPI master: configurable word width, SCLK divider, all four SPI modes (per-transfer
//  CPOL/CPHA) and NUM_SS active-low slave selects. Next-generation master for the SPI subsystem;
//  sits between the user control/FND logic and one or more SPI slaves on a shared SCLK/MOSI/MISO.
// PARAMETERS
//  DATA_W   8  bits per transfer, MSB first; legal >=2
//  NUM_SS   4  number of slave-select lines; legal >=1
//  CLK_DIV  4  clk cycles per SCLK half-period; legal >=1
// PORTS
//  clk      in   1             system clock; all logic on rising edge
//  rst      in   1             asynchronous, active-low reset
//  start    in   1             transfer request; honoured only while tx_ready=1
//  tx_data  in   DATA_W        word to send; latched on accepted start
//  ss_sel   in   $clog2(NUM_SS) (min 1) target slave index; latched on accepted start
//  cpol     in   1             SCLK idle level; latched on accepted start
//  cpha     in   1             0: sample on leading edge; 1: sample on trailing edge
//  tx_ready out  1             1 = IDLE, start will be accepted
//  busy     out  1             1 from accepted start through the DONE cycle
//  done     out  1             1-cycle pulse at end of transfer
//  rx_data  out  DATA_W        word received; updated only in the done cycle, held otherwise
//  SCLK     out  1             serial clock
//  MOSI     out  1             master out
//  MISO     in   1             master in
//  SS_n     out  NUM_SS        slave selects, active low, at most one low
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; tx_ready=1, busy=0, done=0, rx_data=0, SCLK=0, MOSI=0, SS_n=all 1,
//   divider and bit counter =0. Reset mid-transfer aborts immediately; no done pulse.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
//   IDLE : SCLK = cpol input (registered each cycle). start && ss_sel<NUM_SS -> SETUP at T+1, latch
//          tx_data/ss_sel/cpol/cpha. start with ss_sel>=NUM_SS is ignored (stay IDLE, no outputs change).
//   SETUP: SS_n[ss_sel]=0 from T+1; if cpha=0 MOSI=tx_data[DATA_W-1] from T+1. Lasts CLK_DIV cycles.
//   SHIFT: 2*DATA_W half-periods of CLK_DIV cycles; SCLK toggles at start of each half-period.
//          cpha=0: sample MISO on leading edge, drive next MOSI bit on trailing edge.
//          cpha=1: drive MOSI bit on leading edge, sample MISO on trailing edge.
//          Bit counter counts sampled bits 0..DATA_W-1; after last trailing edge SCLK = cpol.
//   HOLD : SCLK idle, SS_n still asserted, CLK_DIV cycles; MOSI holds last bit.
//   DONE : one cycle: SS_n=all 1, done=1, rx_data=shift register, busy=1, tx_ready=0.
//  Latency: start accepted at T -> done at T+1+(2*DATA_W+2)*CLK_DIV; tx_ready=1 at the cycle after.
//  start while busy or in DONE cycle is dropped (no queueing). Input changes after acceptance ignored.
//  Divider counts 0..CLK_DIV-1, wraps; CLK_DIV=1 gives SCLK = clk/2.
//  tx_ready = (state==IDLE); busy = !tx_ready.
// STRUCTURE
//  spi_pkg: typedef enum logic [2:0] spi_state_t {IDLE,SETUP,SHIFT,HOLD,DONE}; typedef struct
//   {cpol,cpha} spi_mode_t; localparams for mode encodings.
//  Sub-module spi_sclk_div: CLK_DIV half-period tick generator (en, tick); FSM+shift regs in top.
// TESTING
//  1 Mode 0, DATA_W=8, CLK_DIV=4, tx 0xA5, MISO loopback -> rx_data=0xA5, done at T+73, 8 rising SCLK.
//  2 Modes 1/2/3 vs. behavioural slave returning 0x3C -> rx_data=0x3C each; SCLK idle = cpol.
//  3 ss_sel=2, NUM_SS=4 -> only SS_n[2] low (0b1011) for 72 cycles; ss_sel=5 (NUM_SS=4) ignored.
//  4 start held high through transfer -> exactly one done; start in done cycle dropped.
//  5 rst=0 at mid-SHIFT bit 4 -> SS_n=all 1, SCLK=0, tx_ready=1 asynchronously; no done.
//  6 DATA_W=16, CLK_DIV=1, tx 0xBEEF loopback -> rx_data=0xBEEF at T+35.

Source files
------------

// File: rtl/spi_master_multi_pkg.sv
// Shared types for the multi-slave SPI master.
//   spi_state_t : transfer sequencer states
//   spi_mode_t  : per-transfer clock polarity/phase, latched on start
package spi_master_multi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StDone
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t Mode0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t Mode1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t Mode2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t Mode3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_master_multi_sclk_div.sv
// SCLK half-period tick generator.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : count while high; held at zero otherwise
//   tick_o        : high on the last clk cycle of each ClkDiv-cycle half-period
module spi_master_multi_sclk_div #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntW'(ClkDiv - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with configurable word width, SCLK divider, per-transfer CPOL/CPHA and
// NUM_SS active-low slave selects. MSB first.
//   clk, rst           : clock, async active-low reset
//   start, tx_data,
//   ss_sel, cpol, cpha : transfer request and its parameters, latched when accepted
//   tx_ready, busy     : idle / transfer in progress (busy includes the done cycle)
//   done, rx_data      : one-cycle completion pulse and received word
//   SCLK, MOSI, MISO,
//   SS_n               : SPI bus
module spi_master_multi
  import spi_master_multi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_SS  = 4,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned SelW   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SelW-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              lead_q, lead_d;  // most recent SCLK toggle was a leading edge
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              done_q, done_d;

  logic tick;
  logic div_en;
  logic sel_ok;
  logic edge_lead, edge_trail;
  logic do_sample, do_drive;

  assign div_en = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
  assign sel_ok = (32'(ss_sel) < NUM_SS);

  spi_master_multi_sclk_div #(
    .ClkDiv(CLK_DIV)
  ) u_sclk_div (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (div_en),
    .tick_o(tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    bit_d      = bit_q;
    lead_d     = lead_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    done_d     = 1'b0;
    edge_lead  = 1'b0;
    edge_trail = 1'b0;

    unique case (state_q)
      StIdle: begin
        sclk_d = cpol;
        if (start && sel_ok) begin
          state_d = StSetup;
          mode_d  = '{cpol: cpol, cpha: cpha};
          bit_d   = '0;
          lead_d  = 1'b0;
          for (int unsigned i = 0; i < NUM_SS; i++) begin
            ss_n_d[i] = (32'(ss_sel) != i);
          end
          if (!cpha) begin
            // First bit must be on the wire before the first (sampling) edge.
            mosi_d = tx_data[DATA_W-1];
            tx_d   = {tx_data[DATA_W-2:0], 1'b0};
          end else begin
            tx_d   = tx_data;
          end
        end
      end
      StSetup: begin
        if (tick) begin
          state_d   = StShift;
          edge_lead = 1'b1;
        end
      end
      StShift: begin
        if (tick) begin
          if (lead_q) begin
            edge_trail = 1'b1;
          end else if (bit_q == BitW'(DATA_W)) begin
            state_d = StHold;
          end else begin
            edge_lead = 1'b1;
          end
        end
      end
      StHold: begin
        sclk_d = mode_q.cpol;
        if (tick) begin
          state_d   = StDone;
          ss_n_d    = '1;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end
      end
      StDone: begin
        sclk_d  = mode_q.cpol;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (edge_lead || edge_trail) begin
      sclk_d = ~sclk_q;
      lead_d = edge_lead;
    end
    if (edge_trail) begin
      bit_d = bit_q + 1'b1;
    end

    do_sample = mode_q.cpha ? edge_trail : edge_lead;
    // With cpha=0 the final trailing edge has no next bit to present.
    do_drive  = mode_q.cpha ? edge_lead : (edge_trail && (bit_q != BitW'(DATA_W - 1)));

    if (do_sample) begin
      rx_d = {rx_q[DATA_W-2:0], MISO};
    end
    if (do_drive) begin
      mosi_d = tx_q[DATA_W-1];
      tx_d   = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mode_q    <= Mode0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      lead_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      lead_q    <= lead_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == StIdle);
  assign busy     = ~tx_ready;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign SS_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a default-parameter instance exercised with a directed table,
// random transfers against a behavioural SPI slave, and a reset abort; a second instance
// (DATA_W=16, CLK_DIV=1, NUM_SS=3) for the fast-clock and out-of-range select cases.
module tb_spi_master_multi;

  localparam int unsigned W    = 8;
  localparam int unsigned NSS  = 4;
  localparam int unsigned DIV  = 4;
  localparam int unsigned W2   = 16;
  localparam int unsigned NSS2 = 3;
  localparam int unsigned DIV2 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  logic           start = 1'b0;
  logic [W-1:0]   tx_data = '0;
  logic [1:0]     ss_sel = '0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           tx_ready, busy, done;
  logic [W-1:0]   rx_data;
  logic           sclk, mosi, miso;
  logic [NSS-1:0] ss_n;

  spi_master_multi #(
    .DATA_W (W),
    .NUM_SS (NSS),
    .CLK_DIV(DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .ss_sel  (ss_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .tx_ready(tx_ready),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .MISO    (miso),
    .SS_n    (ss_n)
  );

  // Second instance: wide word, fastest SCLK, non-power-of-two select count, loopback
  logic            start2 = 1'b0;
  logic [W2-1:0]   tx_data2 = '0;
  logic [1:0]      ss_sel2 = '0;
  logic            cpol2 = 1'b0;
  logic            cpha2 = 1'b0;
  logic            tx_ready2, busy2, done2;
  logic [W2-1:0]   rx_data2;
  logic            sclk2, mosi2;
  logic [NSS2-1:0] ss_n2;

  spi_master_multi #(
    .DATA_W (W2),
    .NUM_SS (NSS2),
    .CLK_DIV(DIV2)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .tx_data (tx_data2),
    .ss_sel  (ss_sel2),
    .cpol    (cpol2),
    .cpha    (cpha2),
    .tx_ready(tx_ready2),
    .busy    (busy2),
    .done    (done2),
    .rx_data (rx_data2),
    .SCLK    (sclk2),
    .MOSI    (mosi2),
    .MISO    (mosi2),
    .SS_n    (ss_n2)
  );

  // Behavioural SPI slave: loads its reply when selected, samples MOSI on its sample edge
  // and shifts MISO on the opposite edge, as defined by the SPI mode.
  logic         slv_cpol = 1'b0;
  logic         slv_cpha = 1'b0;
  logic [W-1:0] slv_reply = '0;
  logic         loopback = 1'b0;
  logic [W-1:0] slv_tx = '0;
  logic [W-1:0] slv_rx = '0;
  logic         slv_miso = 1'b0;
  logic         slv_sel_q = 1'b0;
  logic         slv_prev_sclk = 1'b0;
  int unsigned  rise_cnt = 0;

  assign miso = loopback ? mosi : slv_miso;

  always @(ss_n or sclk) begin
    if (ss_n != '1 && !slv_sel_q) begin
      slv_tx = slv_reply;
      if (!slv_cpha) begin
        slv_miso = slv_tx[W-1];
        slv_tx   = {slv_tx[W-2:0], 1'b0};
      end
    end else if (ss_n != '1 && sclk != slv_prev_sclk) begin
      if (sclk) rise_cnt++;
      if ((sclk != slv_cpol) == !slv_cpha) begin
        slv_rx = {slv_rx[W-2:0], mosi};
      end else begin
        slv_miso = slv_tx[W-1];
        slv_tx   = {slv_tx[W-2:0], 1'b0};
      end
    end
    slv_sel_q     = (ss_n != '1);
    slv_prev_sclk = sclk;
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what the master should return for a transfer.
  function automatic logic [W-1:0] ref_rx(input logic lp, input logic [W-1:0] tx,
                                          input logic [W-1:0] reply);
    return lp ? tx : reply;
  endfunction

  task automatic run_xfer(input logic m_cpol, input logic m_cpha, input logic [W-1:0] m_tx,
                          input logic [W-1:0] m_reply, input logic [1:0] m_sel,
                          input logic m_loop, input logic m_hold, input logic [W-1:0] exp_rx);
    int unsigned    t_acc, t_done, ss_bad, rise0;
    logic [NSS-1:0] exp_ss;
    bit             seen;
    @(negedge clk);
    cpol      = m_cpol;
    cpha      = m_cpha;
    slv_cpol  = m_cpol;
    slv_cpha  = m_cpha;
    slv_reply = m_reply;
    loopback  = m_loop;
    @(negedge clk);
    chk("idle_sclk", 32'(sclk), 32'(m_cpol));
    chk("idle_ready", 32'(tx_ready), 1);
    tx_data = m_tx;
    ss_sel  = m_sel;
    start   = 1'b1;
    t_acc   = cyc;
    exp_ss  = '1;
    exp_ss[m_sel] = 1'b0;
    rise0   = rise_cnt;
    ss_bad  = 0;
    t_done  = 0;
    seen    = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // Accepted: later input changes must have no effect.
        if (!m_hold) start = 1'b0;
        tx_data = ~m_tx;
        ss_sel  = ~m_sel;
        cpol    = ~m_cpol;
        cpha    = ~m_cpha;
      end
      if (done) begin
        seen   = 1;
        t_done = cyc;
      end else if (ss_n !== exp_ss || busy !== 1'b1) begin
        ss_bad++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("done_latency", t_done, t_acc + 1 + (2 * W + 2) * DIV);
    chk("ss_during_xfer", ss_bad, 0);
    chk("rx_data", 32'(rx_data), 32'(exp_rx));
    chk("slave_saw_tx", 32'(slv_rx), 32'(m_tx));
    chk("sclk_rises", rise_cnt - rise0, W);
    chk("done_ss_high", 32'(ss_n), 32'(4'hF));
    chk("done_busy", 32'(busy), 1);
    cpol = m_cpol;
    cpha = m_cpha;
    @(negedge clk);
    start = 1'b0;
    chk("after_ready", 32'(tx_ready), 1);
    chk("after_done_low", 32'(done), 0);
    chk("after_sclk_idle", 32'(sclk), 32'(m_cpol));
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] reply;
    logic [1:0] sel;
    logic       loop;
    logic       hold;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned t, t_done, n_done;
    logic        r_cpol, r_cpha, r_loop;
    logic [W-1:0] r_tx, r_reply;
    logic [1:0]  r_sel;

    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h00, 2'd0, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'h96, 8'h3C, 2'd1, 1'b0, 1'b0, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 8'h69, 8'h3C, 2'd3, 1'b0, 1'b0, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 1'b0, 8'h5A, 8'hC3, 2'd2, 1'b0, 1'b0, 8'hC3};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h7E, 2'd2, 1'b0, 1'b1, 8'h7E};

    // Reset state, with cpol input high to show reset wins over idle tracking
    cpol = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx", 32'(rx_data), 0);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_ss", 32'(ss_n), 32'(4'hF));
    cpol = 1'b0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table: loopback, the four modes, select decode, start held through transfer
    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].cpol, vecs[i].cpha, vecs[i].tx, vecs[i].reply, vecs[i].sel,
               vecs[i].loop, vecs[i].hold, vecs[i].exp_rx);
    end

    // Random transfers against the slave model
    for (int i = 0; i < 20; i++) begin
      r_cpol  = 1'($urandom_range(0, 1));
      r_cpha  = 1'($urandom_range(0, 1));
      r_tx    = 8'($urandom);
      r_reply = 8'($urandom);
      r_sel   = 2'($urandom_range(0, 3));
      r_loop  = ($urandom_range(0, 3) == 0);
      run_xfer(r_cpol, r_cpha, r_tx, r_reply, r_sel, r_loop, 1'b0,
               ref_rx(r_loop, r_tx, r_reply));
    end

    // Reset during bit 4 of a mode-0 transfer
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; slv_cpol = 1'b0; slv_cpha = 1'b0;
    loopback = 1'b0; slv_reply = 8'h33;
    @(negedge clk);
    tx_data = 8'hC6; ss_sel = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1 + 9 * DIV) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_sclk_high", 32'(sclk), 1);
    rst = 1'b0;
    #1;
    chk("abort_ss", 32'(ss_n), 32'(4'hF));
    chk("abort_sclk", 32'(sclk), 0);
    chk("abort_ready", 32'(tx_ready), 1);
    chk("abort_rx", 32'(rx_data), 0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);

    // 16-bit loopback, CLK_DIV=1
    @(negedge clk);
    tx_data2 = 16'hBEEF; ss_sel2 = 2'd1; start2 = 1'b1;
    t = cyc;
    @(negedge clk);
    start2 = 1'b0; tx_data2 = 16'h0000;
    chk("w16_ss", 32'(ss_n2), 32'(3'b101));
    t_done = 0;
    for (int i = 0; i < 100 && t_done == 0; i++) begin
      @(negedge clk);
      if (done2) t_done = cyc;
    end
    chk("w16_latency", t_done, t + 1 + (2 * W2 + 2) * DIV2);
    chk("w16_rx", 32'(rx_data2), 32'h0000BEEF);

    // Out-of-range select is ignored
    repeat (2) @(negedge clk);
    ss_sel2 = 2'd3; tx_data2 = 16'h1234; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("badsel_ready", 32'(tx_ready2), 1);
    chk("badsel_busy", 32'(busy2), 0);
    chk("badsel_ss", 32'(ss_n2), 32'(3'b111));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
